dispatch_credit_ctrl: RTL and testbench

//  Consumer end of the rename->dispatch pipeline register. Takes the registered disPkt bundle

---
 rtl/dispatch_credit_ctrl_pkg.sv | 13 +
 rtl/dispatch_credit_ctrl_credit_counter.sv | 36 +++
 rtl/dispatch_credit_ctrl.sv | 86 ++++++++
 tb/tb_dispatch_credit_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/dispatch_credit_ctrl_pkg.sv
// dispatch_credit_ctrl_pkg: shared bundle type, default sizes and dispatch FSM states
package dispatch_credit_ctrl_pkg;
  localparam int DEF_DISPATCH_WIDTH = 4;
  localparam int DEF_ISSUE_QUEUE_SIZE = 8;
  localparam int DEF_SIZE_ACTIVE_LIST = 16;
  localparam int DEF_SIZE_LSQ = 8;
  typedef struct packed {
    logic [7:0] tag;
    logic       isLoad;
    logic       isStore;
  } disPkt;
  typedef enum logic {RUN, RECOVER} dispatch_state_t;
endpackage

// File: rtl/dispatch_credit_ctrl_credit_counter.sv
// credit_counter: free-entry credit register with fit check, saturation error flag and reload
module credit_counter #(
  parameter int SIZE = 8,
  parameter int W = 4,
  localparam int NW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          take,
  input  logic          upd,
  input  logic          reload,
  input  logic [NW-1:0] need,
  input  logic [NW-1:0] freed,
  output logic          fit,
  output logic          err
);
  localparam int CW = $clog2(SIZE + 1);
  localparam int SW = $clog2(SIZE + W + 1) + 1;
  logic [CW-1:0] count;
  logic [SW-1:0] sum;
  logic          over;
  assign fit = SW'(count) >= SW'(need);
  assign sum = SW'(count) - (take ? SW'(need) : SW'(0)) + SW'(freed);
  assign over = sum > SW'(SIZE);
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= CW'(SIZE);
      err <= 1'b0;
    end else if (reload) begin
      count <= CW'(SIZE);
    end else if (upd) begin
      count <= over ? CW'(SIZE) : sum[CW-1:0];
      err <= err | over;
    end
  end
endmodule

// File: rtl/dispatch_credit_ctrl.sv
// dispatch_credit_ctrl: all-or-nothing bundle dispatch gated by IQ/AL/LDQ/STQ credits
module dispatch_credit_ctrl
  import dispatch_credit_ctrl_pkg::*;
#(
  parameter int DISPATCH_WIDTH = DEF_DISPATCH_WIDTH,
  parameter int IQ_SIZE = DEF_ISSUE_QUEUE_SIZE,
  parameter int AL_SIZE = DEF_SIZE_ACTIVE_LIST,
  parameter int LDQ_SIZE = DEF_SIZE_LSQ,
  parameter int STQ_SIZE = DEF_SIZE_LSQ,
  parameter int RECOVER_CYCLES = 4,
  localparam int LW = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         renameReady_i,
  input  disPkt [DISPATCH_WIDTH-1:0]   disPacket_i,
  input  logic                         backendStall_i,
  input  logic [LW-1:0]                iqFreed_i,
  input  logic [LW-1:0]                alFreed_i,
  input  logic [LW-1:0]                ldqFreed_i,
  input  logic [LW-1:0]                stqFreed_i,
  output logic                         stall_o,
  output logic                         dispatchValid_o,
  output disPkt [DISPATCH_WIDTH-1:0]   disPacket_o,
  output logic [LW-1:0]                ldCount_o,
  output logic [LW-1:0]                stCount_o,
  output logic                         creditErr_o
);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  dispatch_state_t state, state_nxt;
  logic [RW-1:0] rcv_cnt, rcv_nxt;
  logic [LW-1:0] ld, st;
  logic [3:0] fit, err;
  logic run, upd, reload, dv;
  always_comb begin
    ld = '0;
    st = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      ld += LW'(disPacket_i[i].isLoad);
      st += LW'(disPacket_i[i].isStore);
    end
  end
  assign run = state == RUN;
  assign dv = run & renameReady_i & (&fit) & ~backendStall_i & ~flush_i & ~reset;
  assign upd = run & ~flush_i;
  assign reload = ~run & ~flush_i & (rcv_cnt == '0);
  assign dispatchValid_o = dv;
  assign stall_o = renameReady_i & ~dv & ~flush_i & ~reset;
  assign disPacket_o = disPacket_i;
  assign ldCount_o = dv ? ld : '0;
  assign stCount_o = dv ? st : '0;
  assign creditErr_o = |err;
  always_comb begin
    state_nxt = state;
    rcv_nxt = rcv_cnt;
    if (flush_i) begin
      state_nxt = RECOVER;
      rcv_nxt = RW'(RECOVER_CYCLES - 1);
    end else if (!run) begin
      state_nxt = (rcv_cnt == '0) ? RUN : RECOVER;
      rcv_nxt = (rcv_cnt == '0) ? rcv_cnt : rcv_cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      rcv_cnt <= '0;
    end else begin
      state <= state_nxt;
      rcv_cnt <= rcv_nxt;
    end
  end
  credit_counter #(.SIZE(IQ_SIZE), .W(DISPATCH_WIDTH)) u_iq (
    .clk, .reset, .take(dv), .upd, .reload, .need(LW'(DISPATCH_WIDTH)),
    .freed(iqFreed_i), .fit(fit[0]), .err(err[0]));
  credit_counter #(.SIZE(AL_SIZE), .W(DISPATCH_WIDTH)) u_al (
    .clk, .reset, .take(dv), .upd, .reload, .need(LW'(DISPATCH_WIDTH)),
    .freed(alFreed_i), .fit(fit[1]), .err(err[1]));
  credit_counter #(.SIZE(LDQ_SIZE), .W(DISPATCH_WIDTH)) u_ldq (
    .clk, .reset, .take(dv), .upd, .reload, .need(ld),
    .freed(ldqFreed_i), .fit(fit[2]), .err(err[2]));
  credit_counter #(.SIZE(STQ_SIZE), .W(DISPATCH_WIDTH)) u_stq (
    .clk, .reset, .take(dv), .upd, .reload, .need(st),
    .freed(stqFreed_i), .fit(fit[3]), .err(err[3]));
endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// tb_dispatch_credit_ctrl: directed scenarios plus random traffic against a credit-ledger model
module tb_dispatch_credit_ctrl;
  import dispatch_credit_ctrl_pkg::*;
  localparam int W = 4, IQ = 8, AL = 12, LDQ = 6, STQ = 4, RC = 4;
  localparam int LW = $clog2(W + 1);
  typedef disPkt [W-1:0] bundle_t;
  logic clk = 0, reset, flush_i, renameReady_i, backendStall_i;
  bundle_t disPacket_i, disPacket_o;
  logic [LW-1:0] iqFreed_i, alFreed_i, ldqFreed_i, stqFreed_i, ldCount_o, stCount_o;
  logic stall_o, dispatchValid_o, creditErr_o;
  int checks = 0, errors = 0;
  int m_iq, m_al, m_ldq, m_stq, m_rcv;
  bit m_rec, m_err;
  always #5 clk = ~clk;
  dispatch_credit_ctrl #(.DISPATCH_WIDTH(W), .IQ_SIZE(IQ), .AL_SIZE(AL), .LDQ_SIZE(LDQ),
    .STQ_SIZE(STQ), .RECOVER_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .renameReady_i(renameReady_i),
    .disPacket_i(disPacket_i), .backendStall_i(backendStall_i), .iqFreed_i(iqFreed_i),
    .alFreed_i(alFreed_i), .ldqFreed_i(ldqFreed_i), .stqFreed_i(stqFreed_i),
    .stall_o(stall_o), .dispatchValid_o(dispatchValid_o), .disPacket_o(disPacket_o),
    .ldCount_o(ldCount_o), .stCount_o(stCount_o), .creditErr_o(creditErr_o));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bundle_t mk(input int nl, input int ns);
    bundle_t b;
    for (int i = 0; i < W; i++) begin
      b[i].tag = 8'($urandom);
      b[i].isLoad = i < nl;
      b[i].isStore = i >= W - ns;
    end
    return b;
  endfunction
  function automatic int clamp(input int v, input int cap);
    return v > cap ? cap : v;
  endfunction
  task automatic step(input bit rst, input bit fl, input bit rr, input bit bs, input bundle_t p,
                      input int fi, input int fa, input int fld, input int fs);
    int ld, st, v;
    bit fit, e_dv, e_st;
    @(negedge clk);
    reset = rst; flush_i = fl; renameReady_i = rr; backendStall_i = bs; disPacket_i = p;
    iqFreed_i = LW'(fi); alFreed_i = LW'(fa); ldqFreed_i = LW'(fld); stqFreed_i = LW'(fs);
    #1;
    ld = 0; st = 0;
    foreach (p[i]) begin ld += int'(p[i].isLoad); st += int'(p[i].isStore); end
    fit = m_iq >= W && m_al >= W && m_ldq >= ld && m_stq >= st;
    e_dv = !rst && !m_rec && rr && fit && !bs && !fl;
    e_st = !rst && rr && !e_dv && !fl;
    check("dispatchValid", dispatchValid_o, e_dv);
    check("stall", stall_o, e_st);
    check("ldCount", ldCount_o, e_dv ? ld : 0);
    check("stCount", stCount_o, e_dv ? st : 0);
    check("pkt_passthru", disPacket_o, p);
    check("creditErr", creditErr_o, m_err);
    if (rst) begin
      m_iq = IQ; m_al = AL; m_ldq = LDQ; m_stq = STQ; m_rec = 0; m_rcv = 0; m_err = 0;
    end else if (fl) begin
      m_rec = 1; m_rcv = RC - 1;
    end else if (m_rec) begin
      if (m_rcv == 0) begin
        m_iq = IQ; m_al = AL; m_ldq = LDQ; m_stq = STQ; m_rec = 0;
      end else m_rcv--;
    end else begin
      v = m_iq - (e_dv ? W : 0) + fi;  m_err |= v > IQ;  m_iq = clamp(v, IQ);
      v = m_al - (e_dv ? W : 0) + fa;  m_err |= v > AL;  m_al = clamp(v, AL);
      v = m_ldq - (e_dv ? ld : 0) + fld; m_err |= v > LDQ; m_ldq = clamp(v, LDQ);
      v = m_stq - (e_dv ? st : 0) + fs;  m_err |= v > STQ; m_stq = clamp(v, STQ);
    end
    @(posedge clk);
  endtask
  function automatic int rnd_free(input int cred, input int cap);
    int room = cap - cred;
    if ($urandom_range(0, 60) == 0) return int'($urandom_range(0, W));
    return int'($urandom_range(0, room < W ? room : W));
  endfunction
  initial begin
    bundle_t z;
    z = mk(0, 0);
    m_iq = 0; m_al = 0; m_ldq = 0; m_stq = 0; m_rec = 0; m_rcv = 0; m_err = 0;
    reset = 1; flush_i = 0; renameReady_i = 0; backendStall_i = 0; disPacket_i = z;
    iqFreed_i = 0; alFreed_i = 0; ldqFreed_i = 0; stqFreed_i = 0;
    @(posedge clk);
    step(1, 0, 0, 0, z, 0, 0, 0, 0);
    // back-to-back bundles drain IQ, third stalls; a same-cycle free does not help
    step(0, 0, 1, 0, mk(1, 1), 0, 0, 0, 0);
    step(0, 0, 1, 0, mk(0, 0), 0, 0, 0, 0);
    step(0, 0, 1, 0, z, 0, 0, 0, 0);
    step(0, 0, 1, 0, z, 4, 4, 0, 0);
    step(0, 0, 1, 0, z, 0, 4, 0, 0);
    // flush while stalled, recover, then dispatch on reload
    step(0, 0, 1, 0, z, 0, 0, 0, 0);
    step(0, 1, 1, 0, z, 0, 0, 0, 0);
    for (int i = 0; i < RC; i++) step(0, 0, 1, 0, z, 2, 2, 0, 0);
    step(0, 0, 1, 0, mk(2, 2), 0, 0, 0, 0);
    // store-queue pressure; a store-free bundle ignores the empty STQ
    step(1, 0, 0, 0, z, 0, 0, 0, 0);
    step(0, 0, 1, 0, mk(0, 2), 0, 4, 0, 0);
    step(0, 0, 1, 0, mk(0, 3), 4, 4, 0, 0);
    step(0, 0, 1, 0, mk(0, 3), 0, 0, 0, 1);
    step(0, 0, 1, 0, mk(0, 3), 0, 0, 0, 0);
    step(0, 0, 1, 0, mk(2, 0), 0, 0, 0, 0);
    // over-free sets the sticky error; reset mid-recover clears everything
    step(1, 0, 0, 0, z, 0, 0, 0, 0);
    step(0, 0, 0, 0, z, 0, 1, 0, 0);
    step(0, 0, 0, 0, z, 0, 0, 0, 0);
    step(0, 1, 1, 0, z, 0, 0, 0, 0);
    step(0, 0, 1, 0, z, 0, 0, 0, 0);
    step(1, 0, 1, 0, z, 0, 0, 0, 0);
    step(0, 0, 1, 0, mk(1, 1), 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bundle_t p;
      int nl, ns;
      nl = int'($urandom_range(0, W));
      ns = int'($urandom_range(0, W - nl));
      p = mk(nl, ns);
      step($urandom_range(0, 150) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0, p, rnd_free(m_iq, IQ), rnd_free(m_al, AL),
           rnd_free(m_ldq, LDQ), rnd_free(m_stq, STQ));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
